// File: rtl/iq_mixer_decimator.sv
// ----------------------------------------------------------------------------
// iq_mixer_decimator
//
// Purpose:
//   Mixes a signed ADC sample stream with the LO sine/cosine pair to form
//   I and Q products. It then integrates DECIMATION consecutive products per
//   channel and dumps the sum. The dumped sum is truncated to OUT_WIDTH MSBs,
//   which is floor rounding. The result is offered to the next stage over a
//   valid/ready handshake.
//   The datapath advances only on sample_clk_ce, in lockstep with the LO
//   generator. The handshake is evaluated on every clk edge.
//
// Ports:
//   clk           system clock
//   arst_n        asynchronous active-low reset
//   sample_clk_ce sample-rate clock enable
//   clear         synchronous frame restart; also clears overrun
//   adc_sample    signed ADC sample              [SAMPLE_WIDTH]
//   sinewave      signed LO sine                 [LO_WIDTH]
//   cosinewave    signed LO cosine               [LO_WIDTH]
//   i_out         signed decimated I result      [OUT_WIDTH]
//   q_out         signed decimated Q result      [OUT_WIDTH]
//   out_valid     result available
//   out_ready     consumer accepts the result
//   overrun       sticky: a result was overwritten before acceptance
// ----------------------------------------------------------------------------
module iq_mixer_decimator #(
   parameter int SAMPLE_WIDTH = 12,
   parameter int LO_WIDTH     = 7,
   parameter int DECIMATION   = 256,
   parameter int OUT_WIDTH    = 16
) (
   input  logic                           clk,
   input  logic                           arst_n,
   input  logic                           sample_clk_ce,
   input  logic                           clear,
   input  logic signed [SAMPLE_WIDTH-1:0] adc_sample,
   input  logic signed [LO_WIDTH-1:0]     sinewave,
   input  logic signed [LO_WIDTH-1:0]     cosinewave,
   output logic signed [OUT_WIDTH-1:0]    i_out,
   output logic signed [OUT_WIDTH-1:0]    q_out,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic                           overrun
);

   localparam int PROD_WIDTH = SAMPLE_WIDTH + LO_WIDTH;
   localparam int CNT_WIDTH  = $clog2(DECIMATION);
   // Growth of clog2(DECIMATION) bits covers DECIMATION full-scale products.
   localparam int ACC_WIDTH  = PROD_WIDTH + CNT_WIDTH;
   localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(DECIMATION - 1);

   // Shared control state
   logic                 r_pipe_valid;
   logic [CNT_WIDTH-1:0] r_count;
   logic                 r_out_valid;
   logic                 r_overrun;

   // Per-channel state: index 0 = I (sine), index 1 = Q (cosine)
   logic signed [LO_WIDTH-1:0]   w_lo   [2];
   logic signed [PROD_WIDTH-1:0] r_prod [2];
   logic signed [ACC_WIDTH-1:0]  r_acc  [2];
   logic signed [ACC_WIDTH-1:0]  w_sum  [2];
   logic signed [OUT_WIDTH-1:0]  r_data [2];

   logic w_stage2;
   logic w_dump;

   assign w_lo[0] = sinewave;
   assign w_lo[1] = cosinewave;

   // A stage-2 step consumes the product captured on the previous ce.
   assign w_stage2 = sample_clk_ce & r_pipe_valid & ~clear;
   // The last product of a frame is added in the same step as the dump.
   // The sample arriving on that edge starts the next frame, so nothing drops.
   assign w_dump   = w_stage2 & (r_count == LAST_COUNT);

   // -------------------------------------------------------------------------
   // Mixer + integrate-and-dump, one instance per channel
   // -------------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_chan
         logic signed [PROD_WIDTH-1:0] w_mult;

         // Size casts sign-extend both operands, so the multiply is full precision.
         assign w_mult    = PROD_WIDTH'(adc_sample) * PROD_WIDTH'(w_lo[gi]);
         assign w_sum[gi] = r_acc[gi] + ACC_WIDTH'(r_prod[gi]);

         always_ff @(posedge clk or negedge arst_n) begin
            if (!arst_n) begin
               r_prod[gi] <= '0;
               r_acc[gi]  <= '0;
               r_data[gi] <= '0;
            end else begin
               if (sample_clk_ce) begin
                  r_prod[gi] <= w_mult;
               end
               if (clear) begin
                  r_acc[gi] <= '0;
               end else if (w_stage2) begin
                  r_acc[gi] <= w_dump ? '0 : w_sum[gi];
               end
               // Keep the MSBs only: truncation gives floor rounding.
               if (w_dump) begin
                  r_data[gi] <= w_sum[gi][ACC_WIDTH-1 -: OUT_WIDTH];
               end
            end
         end
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Frame counter, pipeline flag and output handshake
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_pipe_valid <= 1'b0;
         r_count      <= '0;
         r_out_valid  <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         if (clear) begin
            r_pipe_valid <= 1'b0;
            r_count      <= '0;
            r_overrun    <= 1'b0;
         end else if (sample_clk_ce) begin
            r_pipe_valid <= 1'b1;
            if (r_pipe_valid) begin
               r_count <= w_dump ? '0 : r_count + CNT_WIDTH'(1);
            end
         end

         // w_dump already excludes clear, so this never fights the clear branch.
         if (w_dump) begin
            r_out_valid <= 1'b1;
            if (r_out_valid && !out_ready) begin
               r_overrun <= 1'b1;
            end
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign i_out     = r_data[0];
   assign q_out     = r_data[1];
   assign out_valid = r_out_valid;
   assign overrun   = r_overrun;

endmodule

// File: tb/tb_iq_mixer_decimator.sv
// ----------------------------------------------------------------------------
// tb_iq_mixer_decimator
//
// Purpose:
//   Directed bench for iq_mixer_decimator with DECIMATION=4. It instantiates
//   two copies of the design:
//     - a full-precision copy, OUT_WIDTH=21
//     - a truncating copy, OUT_WIDTH=16
//   A frame-level model sums the products of each frame. Every active cycle,
//   a compare process checks both copies against this model. Literal
//   hand-computed values pin the model at key points.
// ----------------------------------------------------------------------------
module tb_iq_mixer_decimator;

   localparam int S     = 12;
   localparam int L     = 7;
   localparam int D     = 4;
   localparam int ACC_W = S + L + $clog2(D);   // 21
   localparam int OW_A  = 21;
   localparam int OW_B  = 16;

   logic                clk;
   logic                arst_n;
   logic                ce;
   logic                clear;
   logic signed [S-1:0] adc;
   logic signed [L-1:0] sinv;
   logic signed [L-1:0] cosv;
   logic                ready;

   logic signed [OW_A-1:0] i_a, q_a;
   logic                   v_a, o_a;
   logic signed [OW_B-1:0] i_b, q_b;
   logic                   v_b, o_b;

   int errors = 0;
   int checks = 0;

   iq_mixer_decimator #(
      .SAMPLE_WIDTH(S), .LO_WIDTH(L), .DECIMATION(D), .OUT_WIDTH(OW_A)
   ) dut_a (
      .clk(clk), .arst_n(arst_n), .sample_clk_ce(ce), .clear(clear),
      .adc_sample(adc), .sinewave(sinv), .cosinewave(cosv),
      .i_out(i_a), .q_out(q_a), .out_valid(v_a), .out_ready(ready),
      .overrun(o_a)
   );

   iq_mixer_decimator #(
      .SAMPLE_WIDTH(S), .LO_WIDTH(L), .DECIMATION(D), .OUT_WIDTH(OW_B)
   ) dut_b (
      .clk(clk), .arst_n(arst_n), .sample_clk_ce(ce), .clear(clear),
      .adc_sample(adc), .sinewave(sinv), .cosinewave(cosv),
      .i_out(i_b), .q_out(q_b), .out_valid(v_b), .out_ready(ready),
      .overrun(o_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ------------------------------------------------------------------------
   // Frame-level model.
   // Each ce samples one product pair. The pair joins the running frame
   // sum one ce later. The frame's D-th product closes the frame and
   // publishes its full-precision sum.
   // ------------------------------------------------------------------------
   longint m_pend_i, m_pend_q, m_sum_i, m_sum_q, m_frame_i, m_frame_q;
   longint m_i, m_q;
   bit     m_pend_v, m_valid, m_ovr, m_dump;
   int     m_n;

   initial begin
      m_pend_i = 0; m_pend_q = 0; m_sum_i = 0; m_sum_q = 0;
      m_frame_i = 0; m_frame_q = 0; m_i = 0; m_q = 0;
      m_pend_v = 0; m_valid = 0; m_ovr = 0; m_dump = 0; m_n = 0;
      forever begin
         @(posedge clk or negedge arst_n);
         if (!arst_n) begin
            m_pend_v = 0; m_sum_i = 0; m_sum_q = 0; m_n = 0;
            m_valid = 0; m_ovr = 0; m_i = 0; m_q = 0;
         end else begin
            m_dump = 0;
            if (clear) begin
               m_pend_v = 0; m_sum_i = 0; m_sum_q = 0; m_n = 0; m_ovr = 0;
            end else if (ce) begin
               if (m_pend_v) begin
                  m_sum_i += m_pend_i;
                  m_sum_q += m_pend_q;
                  m_n++;
                  if (m_n == D) begin
                     m_dump = 1;
                     m_frame_i = m_sum_i;
                     m_frame_q = m_sum_q;
                     m_sum_i = 0; m_sum_q = 0; m_n = 0;
                  end
               end
               m_pend_i = longint'(adc) * longint'(sinv);
               m_pend_q = longint'(adc) * longint'(cosv);
               m_pend_v = 1;
            end
            if (m_dump) begin
               if (m_valid && !ready) m_ovr = 1;
               m_valid = 1;
               m_i = m_frame_i;
               m_q = m_frame_q;
            end else if (ready) begin
               m_valid = 0;
            end
         end
      end
   end

   // Compare process: both copies against the model at every negedge out of reset.
   initial begin
      forever begin
         @(negedge clk);
         if (arst_n) begin
            check("cmp_valid_a", longint'(v_a), longint'(m_valid));
            check("cmp_ovr_a",   longint'(o_a), longint'(m_ovr));
            check("cmp_i_a",     longint'(i_a), m_i);
            check("cmp_q_a",     longint'(q_a), m_q);
            check("cmp_valid_b", longint'(v_b), longint'(m_valid));
            check("cmp_ovr_b",   longint'(o_b), longint'(m_ovr));
            check("cmp_i_b",     longint'(i_b), m_i >>> (ACC_W - OW_B));
            check("cmp_q_b",     longint'(q_b), m_q >>> (ACC_W - OW_B));
         end
      end
   end

   // One clock of stimulus: inputs change just after a negedge, held to the next.
   task automatic cyc(input bit c, input int a, input int s, input int co, input bit r);
      ce    = c;
      adc   = S'(a);
      sinv  = L'(s);
      cosv  = L'(co);
      ready = r;
      clear = 1'b0;
      @(negedge clk);
   endtask

   // Drain any pending result, then pulse clear on an edge without a dump.
   task automatic do_clear();
      cyc(1'b0, 0, 0, 0, 1'b1);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   initial begin
      arst_n = 1'b0;
      ce = 1'b0; clear = 1'b0; adc = '0; sinv = '0; cosv = '0; ready = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_valid", longint'(v_a), 0);
      check("reset_i",     longint'(i_a), 0);
      check("reset_ovr",   longint'(o_a), 0);
      arst_n = 1'b1;

      // 1: constant tone, full precision
      do_clear();
      repeat (5) cyc(1'b1, 100, 63, 0, 1'b1);
      check("t1_valid", longint'(v_a), 1);
      check("t1_i",     longint'(i_a), 25200);
      check("t1_q",     longint'(q_a), 0);
      cyc(1'b1, 100, 63, 0, 1'b1);
      check("t1_pulse", longint'(v_a), 0);
      repeat (7) cyc(1'b1, 100, 63, 0, 1'b1);

      // 2: extreme operands, no wrap
      do_clear();
      repeat (5) cyc(1'b1, -2048, -64, 63, 1'b1);
      check("t2_i",   longint'(i_a), 524288);
      check("t2_q",   longint'(q_a), -516096);
      check("t2_i16", longint'(i_b), 16384);
      check("t2_q16", longint'(q_b), -16128);

      // 3: truncation with floor rounding
      do_clear();
      repeat (5) cyc(1'b1, 100, 63, 0, 1'b1);
      check("t3_pos16", longint'(i_b), 787);
      do_clear();
      repeat (5) cyc(1'b1, -100, 63, 0, 1'b1);
      check("t3_neg16", longint'(i_b), -788);

      // 4: overrun while the consumer stalls
      do_clear();
      repeat (4) cyc(1'b1, 100, 63, 0, 1'b0);
      repeat (4) cyc(1'b1, 200, 63, 0, 1'b0);
      cyc(1'b1, 0, 63, 0, 1'b0);
      check("t4_ovr",   longint'(o_a), 1);
      check("t4_valid", longint'(v_a), 1);
      check("t4_i",     longint'(i_a), 50400);
      cyc(1'b0, 0, 63, 0, 1'b0);
      check("t4_hold",  longint'(i_a), 50400);
      cyc(1'b0, 0, 63, 0, 1'b1);
      check("t4_accept", longint'(v_a), 0);
      check("t4_sticky", longint'(o_a), 1);
      do_clear();
      check("t4_clr_ovr", longint'(o_a), 0);

      // 5: ce on 1 of 3 cycles, accept on the same edge as the next dump
      do_clear();
      for (int k = 0; k < 9; k++) begin
         cyc(1'b1, (k < 4) ? 100 : ((k < 8) ? 200 : 0), 63, 0, (k == 8));
         if (k == 4) begin
            check("t5_f1_i",     longint'(i_a), 25200);
            check("t5_f1_valid", longint'(v_a), 1);
         end
         if (k == 8) begin
            check("t5_f2_i",     longint'(i_a), 50400);
            check("t5_f2_valid", longint'(v_a), 1);
            check("t5_f2_ovr",   longint'(o_a), 0);
         end
         cyc(1'b0, 0, 63, 0, 1'b0);
         cyc(1'b0, 0, 63, 0, 1'b0);
      end
      check("t5_still_valid", longint'(v_a), 1);

      // 6: reset mid-frame with a pending result
      do_clear();
      repeat (5) cyc(1'b1, 100, 63, 0, 1'b0);
      cyc(1'b1, 100, 63, 0, 1'b0);
      #2 arst_n = 1'b0;
      #1;
      check("t6_rst_valid", longint'(v_a), 0);
      check("t6_rst_i",     longint'(i_a), 0);
      check("t6_rst_q",     longint'(q_a), 0);
      check("t6_rst_ovr",   longint'(o_a), 0);
      @(negedge clk);
      #2 arst_n = 1'b1;
      repeat (4) cyc(1'b1, 300, 63, 0, 1'b1);
      check("t6_no_early", longint'(v_a), 0);
      cyc(1'b1, 0, 63, 0, 1'b1);
      check("t6_valid", longint'(v_a), 1);
      check("t6_i",     longint'(i_a), 75600);
      check("t6_i16",   longint'(i_b), 2362);
      repeat (3) cyc(1'b0, 0, 0, 0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/iq_mixer_decimator.md
Name: iq_mixer_decimator

Overview:
- Downstream consumer of the quarter-wave sine/cosine LO generator.
- Multiplies each signed ADC sample by the LO sine and cosine to form the I and Q products.
- Sums DECIMATION consecutive products (integrate-and-dump) and hands the decimated I/Q pair to the next SDR stage over a valid/ready handshake.
- Shares the generator's clk and sample_clk_ce, so the mixer pipeline advances in lockstep with the LO.

Parameters:
- SAMPLE_WIDTH, 12, signed ADC sample width.
- LO_WIDTH, 7, signed sine/cosine width; must match the generator's DATA_WIDTH.
- DECIMATION, 256, products per output frame; must be >= 2.
- OUT_WIDTH, 16, output width; must be <= ACC_WIDTH.
- Localparam ACC_WIDTH = SAMPLE_WIDTH + LO_WIDTH + clog2(DECIMATION).

Ports:
- clk  in  1  system clock.
- arst_n  in  1  asynchronous active-low reset.
- sample_clk_ce  in  1  sample-rate clock enable.
- clear  in  1  synchronous: restarts the frame and clears overrun.
- adc_sample  in  SAMPLE_WIDTH  signed ADC sample.
- sinewave  in  LO_WIDTH  signed LO sine.
- cosinewave  in  LO_WIDTH  signed LO cosine.
- i_out  out  OUT_WIDTH  signed decimated in-phase result.
- q_out  out  OUT_WIDTH  signed decimated quadrature result.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- overrun  out  1  sticky: a result was overwritten before it was accepted.

Behaviour:
- Reset: one clock, clk. Reset is asynchronous and active-low (arst_n). While arst_n=0:
  - All registers are 0: i_out=0, q_out=0, out_valid=0, overrun=0.
  - Sample counter=0, accumulators=0, pipe_valid=0.
- All datapath registers advance only on clk edges where sample_clk_ce=1. The handshake logic is evaluated on every clk edge.
- Stage 1 (ce):
  - prod_i <= adc_sample * sinewave and prod_q <= adc_sample * cosinewave.
  - Full-precision signed multiply, SAMPLE_WIDTH+LO_WIDTH bits.
  - pipe_valid <= 1.
- Stage 2 (ce, pipe_valid=1), count < DECIMATION-1:
  - acc += sign-extended prod.
  - count++.
- Stage 2 dump (ce, pipe_valid=1), count == DECIMATION-1:
  - i_out/q_out <= (acc + prod)[ACC_WIDTH-1 -: OUT_WIDTH]. This is truncation of LSBs with arithmetic (floor) rounding.
  - acc <= 0, count <= 0, out_valid <= 1.
  - No input sample is ever dropped between frames.
- Latency: a sample presented on ce n contributes on ce n+1. A frame of DECIMATION samples is complete at i_out/q_out one clk after the ce that captures its last product.
- Accumulator arithmetic is two's complement, ACC_WIDTH bits. It cannot overflow for any legal input, including -2^(S-1) * -2^(L-1).
- Handshake:
  - out_valid stays 1 until a clk edge with out_ready=1. On that edge it goes to 0, unless a dump occurs on the same edge, in which case it stays 1 and the new data loads with no overrun.
  - A dump while out_valid=1 and out_ready=0: the new data overwrites the old, out_valid stays 1, and overrun <= 1.
  - i_out/q_out are stable whenever out_valid=1 and no dump occurs.
- clear=1 at a clk edge (independent of ce):
  - acc=0, count=0, pipe_valid=0, overrun=0.
  - out_valid and the output data are untouched.
  - clear takes priority over a simultaneous dump; that dump is discarded.
- sample_clk_ce=0: the datapath holds. The handshake still completes.
- arst_n asserted mid-frame: the partial frame is discarded and the pending output is lost. After release, the first frame begins with the first ce.

Test Plan:
1. Config S=12, L=7, D=4, OUT_WIDTH=21, ce=1. Stimulus: adc=100, sine=63, cos=0, out_ready=1 -> a single out_valid pulse per 4 ce, i_out=25200, q_out=0.
2. Same config, adc=-2048, sine=-64, cos=63 -> i_out=524288, q_out=-516096. No wrap.
3. OUT_WIDTH=16, stimulus as in 1 -> i_out=787 (25200>>5). With adc=-100: i_out=-788 (floor).
4. out_ready=0 for 2 frames, adc=100 then 200 (sine=63) -> overrun=1, out_valid stays 1, i_out=50400. Then out_ready=1 for one clk -> out_valid=0. Pulse clear -> overrun=0.
5. ce toggling 1-of-3 cycles, with out_ready=1 asserted on the same edge as a dump -> results are identical to the ce=1 case; out_valid stays 1 and carries the new frame, with no overrun.
6. arst_n low for 1 clk mid-frame (after 2 of 4 samples) -> all outputs 0 immediately. The next out_valid comes after 4 fresh samples, with exactly 4 products summed.
